// File: rtl/oup_wb_seg7.sv
// Wishbone B4 classic slave driving the six DE10-Lite 7-segment displays with hex font, DP, enable and blink.
// Optional raw segment mode (registers at 0x14-0x1C) is built when OUP_SEG7_RAW_EN is defined.
module oup_wb_seg7 #(
  parameter logic [31:0] BASE_ADDR         = 32'h9000_0000,
  parameter logic [31:0] ADDR_MASK         = 32'h0000_001F,
  parameter logic [31:0] BLINK_DIV_DEFAULT = 32'd25_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [7:0]  hex0_o,
  output logic [7:0]  hex1_o,
  output logic [7:0]  hex2_o,
  output logic [7:0]  hex3_o,
  output logic [7:0]  hex4_o,
  output logic [7:0]  hex5_o
);

  localparam logic [2:0] OFF_DIGITS = 3'd0;
  localparam logic [2:0] OFF_DP     = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_DIV    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  enable;
  logic [5:0]  blink_mask;
  logic [31:0] blink_div;
  logic [31:0] counter;
  logic        phase;

  logic        wr_q;
  logic [2:0]  wr_off;
  logic [31:0] wr_dat;
  logic [3:0]  wr_sel;

  logic [2:0]  off;
  logic        hit, req, rsv, bad;
  logic [31:0] rd_data;
  logic [7:0]  hex_nxt [6];

`ifdef OUP_SEG7_RAW_EN
  logic        raw_mode;
  logic [31:0] raw_lo;
  logic [15:0] raw_hi;
  logic [47:0] raw_all;
  assign raw_all = {raw_hi, raw_lo};
  assign rsv     = 1'b0;
`else
  assign rsv     = (off > OFF_STATUS);
`endif

  assign off = adr_i[4:2];
  assign hit = ((adr_i & ~ADDR_MASK) == BASE_ADDR);
  assign req = cyc_i & stb_i & hit & ~(ack_o | err_o);
  assign bad = rsv | (we_i & (off == OFF_STATUS));

  function automatic logic [6:0] seg_font(input logic [3:0] v);
    case (v)
      4'h0: seg_font = 7'h40;  4'h1: seg_font = 7'h79;
      4'h2: seg_font = 7'h24;  4'h3: seg_font = 7'h30;
      4'h4: seg_font = 7'h19;  4'h5: seg_font = 7'h12;
      4'h6: seg_font = 7'h02;  4'h7: seg_font = 7'h78;
      4'h8: seg_font = 7'h00;  4'h9: seg_font = 7'h10;
      4'hA: seg_font = 7'h08;  4'hB: seg_font = 7'h03;
      4'hC: seg_font = 7'h46;  4'hD: seg_font = 7'h21;
      4'hE: seg_font = 7'h06;  default: seg_font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_DIGITS: rd_data = {8'd0, digits};
      OFF_DP:     rd_data = {26'd0, dp};
      OFF_CTRL:   rd_data = {18'd0, blink_mask, 2'd0, enable};
      OFF_DIV:    rd_data = blink_div;
      OFF_STATUS: rd_data = {31'd0, phase};
`ifdef OUP_SEG7_RAW_EN
      3'd5:       rd_data = {31'd0, raw_mode};
      3'd6:       rd_data = raw_lo;
      3'd7:       rd_data = {16'd0, raw_hi};
`endif
      default:    rd_data = '0;
    endcase
  end

  // The request is captured here and the write itself lands at the end of the ack cycle,
  // so a reset during the ack cycle discards it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      dat_o  <= '0;
      wr_q   <= 1'b0;
      wr_off <= '0;
      wr_dat <= '0;
      wr_sel <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      wr_q  <= 1'b0;
      if (req) begin
        ack_o  <= ~bad;
        err_o  <= bad;
        wr_q   <= we_i & ~bad;
        wr_off <= off;
        wr_dat <= dat_i;
        wr_sel <= sel_i;
        if (!we_i && !bad) dat_o <= rd_data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digits     <= '0;
      dp         <= '0;
      enable     <= 6'h3F;
      blink_mask <= '0;
      blink_div  <= BLINK_DIV_DEFAULT;
`ifdef OUP_SEG7_RAW_EN
      raw_mode   <= 1'b0;
      raw_lo     <= '0;
      raw_hi     <= '0;
`endif
    end else if (wr_q) begin
      case (wr_off)
        OFF_DIGITS: begin
          for (int b = 0; b < 3; b++)
            if (wr_sel[b]) digits[8*b +: 8] <= wr_dat[8*b +: 8];
        end
        OFF_DP: if (wr_sel[0]) dp <= wr_dat[5:0];
        OFF_CTRL: begin
          if (wr_sel[0]) enable     <= wr_dat[5:0];
          if (wr_sel[1]) blink_mask <= wr_dat[13:8];
        end
        OFF_DIV: begin
          for (int b = 0; b < 4; b++)
            if (wr_sel[b]) blink_div[8*b +: 8] <= wr_dat[8*b +: 8];
        end
`ifdef OUP_SEG7_RAW_EN
        3'd5: if (wr_sel[0]) raw_mode <= wr_dat[0];
        3'd6: begin
          for (int b = 0; b < 4; b++)
            if (wr_sel[b]) raw_lo[8*b +: 8] <= wr_dat[8*b +: 8];
        end
        3'd7: begin
          for (int b = 0; b < 2; b++)
            if (wr_sel[b]) raw_hi[8*b +: 8] <= wr_dat[8*b +: 8];
        end
`endif
        default: ;
      endcase
    end
  end

  // A BLINK_DIV write restarts the blink cycle and wins over a coincident wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if ((wr_q && wr_off == OFF_DIV) || blink_div == 32'd0) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (counter == blink_div - 32'd1) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + 32'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      hex_nxt[n] = {~dp[n], seg_font(digits[4*n +: 4])};
`ifdef OUP_SEG7_RAW_EN
      if (raw_mode) hex_nxt[n] = ~raw_all[8*n +: 8];
`endif
      if (!enable[n] || (blink_mask[n] && phase)) hex_nxt[n] = 8'hFF;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hex0_o <= 8'hFF;
      hex1_o <= 8'hFF;
      hex2_o <= 8'hFF;
      hex3_o <= 8'hFF;
      hex4_o <= 8'hFF;
      hex5_o <= 8'hFF;
    end else begin
      hex0_o <= hex_nxt[0];
      hex1_o <= hex_nxt[1];
      hex2_o <= hex_nxt[2];
      hex3_o <= hex_nxt[3];
      hex4_o <= hex_nxt[4];
      hex5_o <= hex_nxt[5];
    end
  end

endmodule

// File: doc/oup_wb_seg7.md
Name: oup_wb_seg7

Overview:
- Wishbone B4 classic slave on the NEORV32 external bus, a peer of the OUP Wishbone interface. It consumes CPU bus cycles and drives the six DE10-Lite 7-segment displays, which are currently left high-Z.
- Holds per-digit hex values, decimal points, enables and a blink mask.
- A programmable prescaler generates the blink phase.
- Segment outputs are registered and active-low.

Parameters:
- BASE_ADDR, 32'h9000_0000, base of the decoded window.
- ADDR_MASK, 32'h0000_001F, address bits ignored when matching BASE_ADDR.
- BLINK_DIV_DEFAULT, 32'd25_000_000, reset value of BLINK_DIV. At 50 MHz this gives 1 Hz toggling.

Ports:
- clk_i  in  1  system clock (50 MHz)
- rst_i  in  1  asynchronous reset, active-high
- adr_i  in  32  byte address
- dat_i  in  32  write data, master to slave
- dat_o  out  32  read data, slave to master
- we_i  in  1  write enable
- sel_i  in  4  byte selects
- stb_i  in  1  strobe
- cyc_i  in  1  cycle
- ack_o  out  1  acknowledge
- err_o  out  1  error
- hex0_o..hex5_o  out  8 each  segments, active-low; bit7 = DP, bits6:0 = g..a

Behaviour:
- Reset values:
  - ack_o=0, err_o=0, dat_o=0, all hex*_o=8'hFF.
  - DIGITS=0, DP=0, CTRL={blink_mask=0, enable=6'h3F}, BLINK_DIV=BLINK_DIV_DEFAULT, counter=0, phase=0.
- Window select: cyc_i & stb_i & ((adr_i & ~ADDR_MASK)==BASE_ADDR). Unselected cycles are ignored: no ack, no err.
- Register map (word offset adr_i[4:2]; adr_i[1:0] ignored):
  - 0x00 DIGITS rw [23:0]: nibble n drives hexn.
  - 0x04 DP rw [5:0]: bit n = 1 lights the DP of hexn.
  - 0x08 CTRL rw: [5:0] digit enable, [13:8] blink mask.
  - 0x0C BLINK_DIV rw [31:0].
  - 0x10 STATUS ro: [0] blink phase.
  - 0x14-0x1C: reserved.
  - Unimplemented bits read 0 and ignore writes.
- Handshake:
  - A selected request in cycle N gives exactly one of ack_o/err_o high in cycle N+1 for one cycle, then low in N+2.
  - No new request is accepted while ack_o|err_o=1, so one request yields one pulse even if stb_i is held.
  - dat_o is valid in the ack cycle and 0 otherwise.
- Writes commit in the ack cycle. Only bytes with sel_i set are updated; sel_i=0 is acked with no change.
- err_o conditions: write to STATUS, or any access to a reserved offset. No register changes on err.
- Blink prescaler:
  - If BLINK_DIV=0: counter and phase are held at 0.
  - Otherwise: counter increments each cycle; at BLINK_DIV-1 it wraps to 0 and phase toggles.
  - Any write to BLINK_DIV clears counter and phase in the same commit cycle, which takes priority over the wrap.
- Display:
  - hexn_o <= blank ? 8'hFF : {~DP[n], seg(DIGITS[4n+3:4n])}.
  - blank = ~enable[n] | (mask[n] & phase).
  - seg uses the standard active-low hex font (0=7'h40, 5=7'h12, A=7'h08, F=7'h0E).
  - Outputs update one cycle after the source register or phase changes.
- Reset asserted mid-transaction clears ack_o/err_o immediately and discards the pending write. The bus master retries after reset.

Optional Feature:
- Macro: OUP_SEG7_RAW_EN.
- Defined:
  - Offset 0x14 RAW_CTRL [0] raw_mode.
  - 0x18 RAW_LO = {hex3,hex2,hex1,hex0} raw bytes.
  - 0x1C RAW_HI [15:0] = {hex5,hex4}.
  - All rw, reset 0.
  - raw_mode=1: each enabled digit outputs ~raw_byte directly (raw bit 1 = segment on); DP register and font are bypassed. Enable and blink still apply.
- Not defined: 0x14-0x1C are reserved and return err_o. Display is font-only.

Test Plan:
- Release reset with no bus traffic -> hex0..5_o=8'hFF for one cycle, then 8'hC0; reads of DIGITS=0, CTRL=32'h0000_003F, BLINK_DIV=25_000_000.
- Write DIGITS=32'h00F5A0, sel=4'hF, then DP=32'h1 -> ack_o single pulse per write; hex0_o=8'h40, hex1_o=8'h88, hex2_o=8'h92, hex3_o=8'h8E, hex4/5_o=8'hC0.
- Write BLINK_DIV=4 and CTRL=32'h0000_013F -> STATUS[0] toggles every 4 cycles; hex0_o alternates between font value and 8'hFF; other digits are steady. Then write BLINK_DIV=0 -> phase stays 0 and hex0_o stays steady.
- Write DIGITS=32'h123456 with sel=4'b0010 -> only nibbles 3:2 updated (read back 32'h003400 from 0); write to STATUS -> err_o pulse, ack_o stays 0; read offset 0x14 (macro off) -> err_o.
- Hold stb_i/cyc_i high for 5 cycles on a read -> ack_o high only in cycle 2 and again in cycle 4 (one per accepted request); adr_i outside window -> no ack/err.
- Assert rst_i in the cycle after a write request (before ack) -> ack_o drops immediately, register keeps its reset value; with OUP_SEG7_RAW_EN, raw_mode=1 and RAW_LO=32'h0000_0080 -> hex0_o=8'h7F.
